// File: rtl/glb_bank_ctrl_mc.sv
// Multi-channel global-buffer bank controller.
// Arbitrates one host config port and NUM_CH packet channels onto a single-port
// bank memory, tracks reads through an RD_LAT-deep pipeline and steers each
// read response back to the port that issued it.
//
// Request/grant semantics (all ports): a request (wr_en or rd_en) is accepted
// in the cycle it is high only if it wins arbitration. Config requests are
// always accepted; a packet request is accepted only when packet_gnt[ch] is
// high in the same cycle. A request that is not granted must be held until it
// is. Priority: cfg write > cfg read > packet (round-robin across channels,
// write beats read inside a channel).
module glb_bank_ctrl_mc #(
   parameter int NUM_CH          = 2,
   parameter int BANK_ADDR_WIDTH = 17,
   parameter int BANK_DATA_WIDTH = 64,
   parameter int CFG_DATA_WIDTH  = 32,
   parameter int RD_LAT          = 3
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_CH-1:0]                    packet_wr_en,
   input  logic [NUM_CH*BANK_ADDR_WIDTH-1:0]    packet_wr_addr,
   input  logic [NUM_CH*BANK_DATA_WIDTH-1:0]    packet_wr_data,
   input  logic [NUM_CH*BANK_DATA_WIDTH-1:0]    packet_wr_data_bit_sel,
   input  logic [NUM_CH-1:0]                    packet_rd_en,
   input  logic [NUM_CH*BANK_ADDR_WIDTH-1:0]    packet_rd_addr,
   output logic [NUM_CH-1:0]                    packet_gnt,
   output logic [NUM_CH*BANK_DATA_WIDTH-1:0]    packet_rd_data,
   output logic [NUM_CH-1:0]                    packet_rd_data_valid,
   input  logic                                 sram_cfg_wr_en,
   input  logic [BANK_ADDR_WIDTH-1:0]           sram_cfg_wr_addr,
   input  logic [CFG_DATA_WIDTH-1:0]            sram_cfg_wr_data,
   input  logic                                 sram_cfg_rd_en,
   input  logic [BANK_ADDR_WIDTH-1:0]           sram_cfg_rd_addr,
   output logic [CFG_DATA_WIDTH-1:0]            sram_cfg_rd_data,
   output logic                                 sram_cfg_rd_data_valid,
   output logic                                 mem_rd_en,
   output logic                                 mem_wr_en,
   output logic [BANK_ADDR_WIDTH-1:0]           mem_addr,
   output logic [BANK_DATA_WIDTH-1:0]           mem_data_in,
   output logic [BANK_DATA_WIDTH-1:0]           mem_data_in_bit_sel,
   input  logic [BANK_DATA_WIDTH-1:0]           mem_data_out
);

   localparam int AW     = BANK_ADDR_WIDTH;
   localparam int DW     = BANK_DATA_WIDTH;
   localparam int CW     = CFG_DATA_WIDTH;
   localparam int NW     = DW / CW;
   localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;
   localparam int IDX_LO = $clog2(CW / 8);
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TAIL   = RD_LAT - 1;

   logic [NUM_CH-1:0] pkt_req;
   logic              gnt_found;
   logic [CH_W-1:0]   gnt_ch;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]  cfg_wr_idx, cfg_rd_idx;
   logic              push_cfg;
   logic [CH_W-1:0]   push_ch;
   logic [IDX_W-1:0]  push_idx;

   // Read-tracking pipeline, entry 0 is the newest, TAIL lines up with mem_data_out.
   logic              pv_q   [RD_LAT];
   logic              pcfg_q [RD_LAT];
   logic [CH_W-1:0]   pch_q  [RD_LAT];
   logic [IDX_W-1:0]  pidx_q [RD_LAT];

   logic [CW-1:0]        cfg_slice;
   logic [CW-1:0]        cfg_held_q;
   logic [NUM_CH*DW-1:0] pkt_held_q;

   // Config word index inside the bank word; empty field when one word fits.
   generate
      if (NW > 1) begin : g_idx
         assign cfg_wr_idx = sram_cfg_wr_addr[IDX_LO +: IDX_W];
         assign cfg_rd_idx = sram_cfg_rd_addr[IDX_LO +: IDX_W];
      end else begin : g_no_idx
         assign cfg_wr_idx = '0;
         assign cfg_rd_idx = '0;
      end
   endgenerate

   function automatic logic [CH_W-1:0] rr_pick(input logic [CH_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_CH) s = s - NUM_CH;
      return CH_W'(s);
   endfunction

   // Round-robin search starting at the pointer for the first requesting channel.
   always_comb begin
      pkt_req   = packet_wr_en | packet_rd_en;
      gnt_found = 1'b0;
      gnt_ch    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!gnt_found && pkt_req[rr_pick(ptr_q, i)]) begin
            gnt_found = 1'b1;
            gnt_ch    = rr_pick(ptr_q, i);
         end
      end
   end

   // Select the single memory access for this cycle and describe the read to track.
   always_comb begin
      mem_wr_en           = 1'b0;
      mem_rd_en           = 1'b0;
      mem_addr            = '0;
      mem_data_in         = '0;
      mem_data_in_bit_sel = '0;
      packet_gnt          = '0;
      push_cfg            = 1'b0;
      push_ch             = '0;
      push_idx            = '0;
      ptr_d               = ptr_q;
      if (sram_cfg_wr_en) begin
         mem_wr_en = 1'b1;
         mem_addr  = sram_cfg_wr_addr;
         for (int w = 0; w < NW; w++) begin
            if (cfg_wr_idx == IDX_W'(w)) begin
               mem_data_in[w*CW +: CW]         = sram_cfg_wr_data;
               mem_data_in_bit_sel[w*CW +: CW] = '1;
            end
         end
      end else if (sram_cfg_rd_en) begin
         mem_rd_en = 1'b1;
         mem_addr  = sram_cfg_rd_addr;
         push_cfg  = 1'b1;
         push_idx  = cfg_rd_idx;
      end else if (gnt_found) begin
         packet_gnt[gnt_ch] = 1'b1;
         ptr_d = (int'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + 1'b1;
         if (packet_wr_en[gnt_ch]) begin
            mem_wr_en           = 1'b1;
            mem_addr            = packet_wr_addr[gnt_ch*AW +: AW];
            mem_data_in         = packet_wr_data[gnt_ch*DW +: DW];
            mem_data_in_bit_sel = packet_wr_data_bit_sel[gnt_ch*DW +: DW];
         end else begin
            mem_rd_en = 1'b1;
            mem_addr  = packet_rd_addr[gnt_ch*AW +: AW];
            push_ch   = gnt_ch;
         end
      end
   end

   // Round-robin pointer moves past the channel that was just served.
   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   // Shift the read descriptor along with the memory latency; reset drops in-flight reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pv_q[i]   <= 1'b0;
            pcfg_q[i] <= 1'b0;
            pch_q[i]  <= '0;
            pidx_q[i] <= '0;
         end
      end else begin
         pv_q[0]   <= mem_rd_en;
         pcfg_q[0] <= push_cfg;
         pch_q[0]  <= push_ch;
         pidx_q[0] <= push_idx;
         for (int i = 1; i < RD_LAT; i++) begin
            pv_q[i]   <= pv_q[i-1];
            pcfg_q[i] <= pcfg_q[i-1];
            pch_q[i]  <= pch_q[i-1];
            pidx_q[i] <= pidx_q[i-1];
         end
      end
   end

   // Steer the returning word to its requester; otherwise show the last delivered value.
   always_comb begin
      cfg_slice            = '0;
      packet_rd_data_valid = '0;
      packet_rd_data       = '0;
      for (int w = 0; w < NW; w++) begin
         if (pidx_q[TAIL] == IDX_W'(w)) cfg_slice = mem_data_out[w*CW +: CW];
      end
      sram_cfg_rd_data_valid = pv_q[TAIL] & pcfg_q[TAIL];
      sram_cfg_rd_data       = sram_cfg_rd_data_valid ? cfg_slice : cfg_held_q;
      for (int c = 0; c < NUM_CH; c++) begin
         packet_rd_data_valid[c] = pv_q[TAIL] & ~pcfg_q[TAIL] & (pch_q[TAIL] == CH_W'(c));
         packet_rd_data[c*DW +: DW] = packet_rd_data_valid[c] ? mem_data_out
                                                              : pkt_held_q[c*DW +: DW];
      end
   end

   // Capture each delivered response so it stays visible until the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_held_q <= '0;
         pkt_held_q <= '0;
      end else begin
         if (sram_cfg_rd_data_valid) cfg_held_q <= cfg_slice;
         for (int c = 0; c < NUM_CH; c++) begin
            if (packet_rd_data_valid[c]) pkt_held_q[c*DW +: DW] <= mem_data_out;
         end
      end
   end

endmodule

// File: tb/tb_glb_bank_ctrl_mc.sv
// Bench for glb_bank_ctrl_mc: behavioural bank memory with RD_LAT latency,
// a reference memory plus round-robin model that predicts grants and read
// data, and an in-order response scoreboard.
module tb_glb_bank_ctrl_mc;

   localparam int NUM_CH  = 2;
   localparam int AW      = 17;
   localparam int DW      = 64;
   localparam int CW      = 32;
   localparam int RD_LAT  = 3;
   localparam int EW      = 1 + 3 + DW;
   localparam int WSEL_LO = $clog2(CW / 8);
   localparam int NWORD   = DW / CW;
   localparam logic [DW-1:0] IDLE_PAT = 64'hBAD0_BAD0_BAD0_BAD0;

   logic                 clk;
   logic                 reset;
   logic [NUM_CH-1:0]    packet_wr_en, packet_rd_en, packet_gnt, packet_rd_data_valid;
   logic [NUM_CH*AW-1:0] packet_wr_addr, packet_rd_addr;
   logic [NUM_CH*DW-1:0] packet_wr_data, packet_wr_data_bit_sel, packet_rd_data;
   logic                 sram_cfg_wr_en, sram_cfg_rd_en, sram_cfg_rd_data_valid;
   logic [AW-1:0]        sram_cfg_wr_addr, sram_cfg_rd_addr;
   logic [CW-1:0]        sram_cfg_wr_data, sram_cfg_rd_data;
   logic                 mem_rd_en, mem_wr_en;
   logic [AW-1:0]        mem_addr;
   logic [DW-1:0]        mem_data_in, mem_data_in_bit_sel, mem_data_out;

   int n_checks = 0;
   int n_pass   = 0;
   int model_ptr = 0;
   logic [EW-1:0] exp_q[$];
   logic [DW-1:0] last_pkt [NUM_CH] = '{default: '0};
   logic [CW-1:0] last_cfg = '0;
   logic [DW-1:0] ref_mem  [256] = '{default: '0};
   logic [DW-1:0] phys_mem [256] = '{default: '0};
   logic [DW-1:0] rd_pipe  [RD_LAT] = '{default: '0};
   int            mon_nv;
   logic [EW-1:0] mon_act, mon_exp;

   glb_bank_ctrl_mc #(
      .NUM_CH(NUM_CH), .BANK_ADDR_WIDTH(AW), .BANK_DATA_WIDTH(DW),
      .CFG_DATA_WIDTH(CW), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .reset(reset),
      .packet_wr_en(packet_wr_en), .packet_wr_addr(packet_wr_addr),
      .packet_wr_data(packet_wr_data), .packet_wr_data_bit_sel(packet_wr_data_bit_sel),
      .packet_rd_en(packet_rd_en), .packet_rd_addr(packet_rd_addr),
      .packet_gnt(packet_gnt), .packet_rd_data(packet_rd_data),
      .packet_rd_data_valid(packet_rd_data_valid),
      .sram_cfg_wr_en(sram_cfg_wr_en), .sram_cfg_wr_addr(sram_cfg_wr_addr),
      .sram_cfg_wr_data(sram_cfg_wr_data), .sram_cfg_rd_en(sram_cfg_rd_en),
      .sram_cfg_rd_addr(sram_cfg_rd_addr), .sram_cfg_rd_data(sram_cfg_rd_data),
      .sram_cfg_rd_data_valid(sram_cfg_rd_data_valid),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_in_bit_sel(mem_data_in_bit_sel),
      .mem_data_out(mem_data_out)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // behavioural bank memory, read data appears RD_LAT cycles after mem_rd_en
   always @(posedge clk) begin
      if (mem_wr_en)
         phys_mem[mem_addr[10:3]] <= (phys_mem[mem_addr[10:3]] & ~mem_data_in_bit_sel) |
                                     (mem_data_in & mem_data_in_bit_sel);
      rd_pipe[0] <= mem_rd_en ? phys_mem[mem_addr[10:3]] : IDLE_PAT;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_data_out = rd_pipe[RD_LAT-1];

   task automatic chk(input string tag, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
   endtask

   // driver tasks
   task automatic set_idle();
      packet_wr_en = '0; packet_rd_en = '0;
      packet_wr_addr = '0; packet_rd_addr = '0;
      packet_wr_data = '0; packet_wr_data_bit_sel = '0;
      sram_cfg_wr_en = 1'b0; sram_cfg_rd_en = 1'b0;
      sram_cfg_wr_addr = '0; sram_cfg_rd_addr = '0; sram_cfg_wr_data = '0;
   endtask

   task automatic drive_wr(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] m);
      packet_wr_en[ch] = 1'b1;
      packet_wr_addr[ch*AW +: AW] = a;
      packet_wr_data[ch*DW +: DW] = d;
      packet_wr_data_bit_sel[ch*DW +: DW] = m;
   endtask

   task automatic drive_rd(input int ch, input logic [AW-1:0] a);
      packet_rd_en[ch] = 1'b1;
      packet_rd_addr[ch*AW +: AW] = a;
   endtask

   // One cycle: predict this cycle's access from the inputs, check it, advance.
   task automatic step();
      logic [NUM_CH-1:0] eg;
      logic ewr, erd;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] emask, edata;
      int wi, a, k, c;
      bit found;
      #1;
      eg = '0; ewr = 0; erd = 0; eaddr = '0; emask = '0; edata = '0;
      found = 0; k = 0; wi = 0; a = 0;
      if (sram_cfg_wr_en) begin
         ewr = 1; eaddr = sram_cfg_wr_addr;
         wi = int'(sram_cfg_wr_addr >> WSEL_LO) % NWORD;
         emask = {{(DW-CW){1'b0}}, {CW{1'b1}}} << (wi*CW);
         edata = {{(DW-CW){1'b0}}, sram_cfg_wr_data} << (wi*CW);
      end else if (sram_cfg_rd_en) begin
         erd = 1; eaddr = sram_cfg_rd_addr;
         wi = int'(sram_cfg_rd_addr >> WSEL_LO) % NWORD;
         a = int'(eaddr[10:3]);
         exp_q.push_back({1'b1, 3'd0, {(DW-CW){1'b0}}, ref_mem[a][wi*CW +: CW]});
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            c = (model_ptr + i) % NUM_CH;
            if (!found && (packet_wr_en[c] || packet_rd_en[c])) begin
               found = 1; k = c;
            end
         end
         if (found) begin
            eg[k] = 1'b1;
            model_ptr = (k + 1) % NUM_CH;
            if (packet_wr_en[k]) begin
               ewr = 1; eaddr = packet_wr_addr[k*AW +: AW];
               emask = packet_wr_data_bit_sel[k*DW +: DW];
               edata = packet_wr_data[k*DW +: DW];
            end else begin
               erd = 1; eaddr = packet_rd_addr[k*AW +: AW];
               a = int'(eaddr[10:3]);
               exp_q.push_back({1'b0, 3'(k), ref_mem[a]});
            end
         end
      end
      if (ewr) begin
         a = int'(eaddr[10:3]);
         ref_mem[a] = (ref_mem[a] & ~emask) | (edata & emask);
      end
      chk("gnt", packet_gnt, eg);
      chk("mem_wr_en", mem_wr_en, ewr);
      chk("mem_rd_en", mem_rd_en, erd);
      if (ewr || erd) chk("mem_addr", mem_addr, eaddr);
      if (ewr) begin
         chk("bit_sel", mem_data_in_bit_sel, emask);
         chk("wdata", mem_data_in & emask, edata & emask);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pkt_write(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] m);
      set_idle();
      drive_wr(ch, a, d, m);
      step();
      set_idle();
   endtask

   task automatic drain();
      for (int i = 0; i < 4*RD_LAT + 8 && exp_q.size() != 0; i++) step();
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // scoreboard: every valid pulse must match the oldest expected response
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         last_cfg = '0;
         for (int c = 0; c < NUM_CH; c++) last_pkt[c] = '0;
      end else begin
         mon_nv = int'(sram_cfg_rd_data_valid) + $countones(packet_rd_data_valid);
         if (mon_nv > 0) begin
            chk("one_valid", mon_nv, 1);
            mon_act = '0;
            if (sram_cfg_rd_data_valid)
               mon_act = {1'b1, 3'd0, {(DW-CW){1'b0}}, sram_cfg_rd_data};
            else
               for (int c = 0; c < NUM_CH; c++)
                  if (packet_rd_data_valid[c])
                     mon_act = {1'b0, 3'(c), packet_rd_data[c*DW +: DW]};
            if (exp_q.size() == 0) begin
               chk("unexp_valid", mon_nv, 0);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("rd_resp", mon_act, mon_exp);
               if (mon_exp[EW-1]) last_cfg = mon_exp[CW-1:0];
               else last_pkt[int'(mon_exp[DW +: 3])] = mon_exp[DW-1:0];
            end
         end
      end
   end

   initial begin
      set_idle();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      model_ptr = 0;

      // idle after reset
      for (int i = 0; i < 10; i++) step();
      chk("rst_cfg_v", sram_cfg_rd_data_valid, 0);
      chk("rst_pkt_v", packet_rd_data_valid, 0);
      chk("rst_cfg_data", sram_cfg_rd_data, 0);
      chk("rst_pkt_data", packet_rd_data, 0);

      // config write to upper word, then read back with exact latency
      sram_cfg_wr_en = 1'b1; sram_cfg_wr_addr = 17'h4; sram_cfg_wr_data = 32'hDEADBEEF;
      #1;
      chk("cfg_wr_bitsel", mem_data_in_bit_sel, 64'hFFFFFFFF_00000000);
      step();
      set_idle();
      sram_cfg_rd_en = 1'b1; sram_cfg_rd_addr = 17'h4;
      step();
      set_idle();
      for (int i = 1; i < RD_LAT; i++) begin
         chk("cfg_lat_early", sram_cfg_rd_data_valid, 0);
         step();
      end
      chk("cfg_lat_hit", sram_cfg_rd_data_valid, 1);
      chk("cfg_rdata", sram_cfg_rd_data, 32'hDEADBEEF);
      step();
      chk("cfg_v_low", sram_cfg_rd_data_valid, 0);
      chk("cfg_held", sram_cfg_rd_data, 32'hDEADBEEF);

      // preload; last write from ch1 leaves the pointer at 0
      pkt_write(0, 17'h100, 64'h0123456789ABCDEF, '1);
      pkt_write(0, 17'h18,  64'h1818_0000_1818_ABCD, '1);
      pkt_write(1, 17'h10,  64'h1010_5555_1010_7777, '1);

      // both channels read continuously: alternating grants, in-order returns
      set_idle();
      drive_rd(0, 17'h10);
      drive_rd(1, 17'h18);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_gnt", packet_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
         step();
      end
      set_idle();
      drain();

      // cfg read blocks a pending ch1 write, which is granted once cfg drops
      set_idle();
      sram_cfg_rd_en = 1'b1; sram_cfg_rd_addr = 17'h4;
      drive_wr(1, 17'h20, 64'hCAFE_F00D_1234_5678, '1);
      #1;
      chk("cfg_blocks_gnt", packet_gnt, 0);
      step();
      sram_cfg_rd_en = 1'b0;
      #1;
      chk("pend_wr_gnt", packet_gnt, 2'b10);
      step();
      set_idle();
      drive_rd(1, 17'h20);
      step();
      set_idle();
      drain();

      // partial bit-mask write merges with existing word
      pkt_write(0, 17'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000);
      drive_rd(0, 17'h20);
      step();
      set_idle();
      drain();

      // single ch1 read: exact latency, held afterwards, ch0 untouched
      drive_rd(1, 17'h100);
      step();
      set_idle();
      for (int i = 1; i < RD_LAT; i++) begin
         chk("ch1_lat_early", packet_rd_data_valid, 0);
         step();
      end
      chk("ch1_lat_hit", packet_rd_data_valid, 2'b10);
      chk("ch1_rdata", packet_rd_data[DW +: DW], 64'h0123456789ABCDEF);
      chk("ch0_unchanged", packet_rd_data[0 +: DW], last_pkt[0]);
      step();
      chk("ch1_v_low", packet_rd_data_valid, 0);
      chk("ch1_held", packet_rd_data[DW +: DW], 64'h0123456789ABCDEF);
      chk("ch0_held", packet_rd_data[0 +: DW], last_pkt[0]);

      // random mixed traffic
      for (int n = 0; n < 60; n++) begin
         set_idle();
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 2) == 0)
               drive_wr(c, AW'($urandom_range(0, 15) << 3), {$urandom(), $urandom()},
                        {$urandom(), $urandom()});
            if ($urandom_range(0, 1) == 0)
               drive_rd(c, AW'($urandom_range(0, 15) << 3));
         end
         if ($urandom_range(0, 7) == 0) begin
            sram_cfg_rd_en = 1'b1;
            sram_cfg_rd_addr = AW'($urandom_range(0, 31) << 2);
         end
         if ($urandom_range(0, 9) == 0) begin
            sram_cfg_wr_en = 1'b1;
            sram_cfg_wr_addr = AW'($urandom_range(0, 31) << 2);
            sram_cfg_wr_data = $urandom();
         end
         step();
      end
      set_idle();
      drain();

      // reset with two reads in flight: nothing may come back
      drive_rd(0, 17'h10);
      step();
      set_idle();
      drive_rd(1, 17'h18);
      step();
      set_idle();
      reset = 1'b1;
      model_ptr = 0;
      step();
      reset = 1'b0;
      for (int i = 0; i < RD_LAT + 3; i++) begin
         chk("rst_no_valid", {sram_cfg_rd_data_valid, packet_rd_data_valid}, 0);
         chk("rst_cfg_zero", sram_cfg_rd_data, 0);
         chk("rst_pkt_zero", packet_rd_data, 0);
         step();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/glb_bank_ctrl_mc.md
Name: glb_bank_ctrl_mc

Overview:
Multi-channel SRAM bank controller for the global buffer. It arbitrates one host SRAM-config port and NUM_CH packet channels onto a single-port bank memory. It tracks reads through a pipeline of parameterised depth and returns each read response to the channel that issued it. Successor to the single-channel bank controller; adds round-robin packet arbitration, per-channel grants, configurable memory read latency, and generalised config word selection.

Parameters:
NUM_CH, 2, number of packet channels (1..8)
BANK_ADDR_WIDTH, 17, byte address width into bank
BANK_DATA_WIDTH, 64, memory word width (power of 2, >= CFG_DATA_WIDTH)
CFG_DATA_WIDTH, 32, config data width (power of 2)
RD_LAT, 3, cycles from mem_rd_en to valid mem_data_out (1..8)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
packet_wr_en  in  NUM_CH  per-channel write request
packet_wr_addr  in  NUM_CH*BANK_ADDR_WIDTH  per-channel write address
packet_wr_data  in  NUM_CH*BANK_DATA_WIDTH  per-channel write data
packet_wr_data_bit_sel  in  NUM_CH*BANK_DATA_WIDTH  per-channel bit write mask
packet_rd_en  in  NUM_CH  per-channel read request
packet_rd_addr  in  NUM_CH*BANK_ADDR_WIDTH  per-channel read address
packet_gnt  out  NUM_CH  one-hot grant, same cycle as request
packet_rd_data  out  NUM_CH*BANK_DATA_WIDTH  per-channel read data (held)
packet_rd_data_valid  out  NUM_CH  per-channel one-cycle read-valid
sram_cfg_wr_en  in  1  config write
sram_cfg_wr_addr  in  BANK_ADDR_WIDTH  config write byte address
sram_cfg_wr_data  in  CFG_DATA_WIDTH  config write data
sram_cfg_rd_en  in  1  config read
sram_cfg_rd_addr  in  BANK_ADDR_WIDTH  config read byte address
sram_cfg_rd_data  out  CFG_DATA_WIDTH  config read data (held)
sram_cfg_rd_data_valid  out  1  config read-valid pulse
mem_rd_en  out  1  memory read enable
mem_wr_en  out  1  memory write enable
mem_addr  out  BANK_ADDR_WIDTH  memory address
mem_data_in  out  BANK_DATA_WIDTH  memory write data
mem_data_in_bit_sel  out  BANK_DATA_WIDTH  memory bit write mask
mem_data_out  in  BANK_DATA_WIDTH  memory read data

Behaviour:
- All clocked state is reset synchronously on rising clk with reset=1. Reset values: all valids 0, held read data 0, RR pointer 0, pipeline empty. Memory outputs are combinational and are 0 while no request is present.
- One memory access per cycle, decided combinationally. Priority order: cfg write > cfg read > packet.
- Packet arbitration: a channel requests if wr_en|rd_en. Round-robin starts at pointer p. The granted channel k has packet_gnt[k]=1. Within a channel, write beats read; the losing request is not granted and the requester must hold it.
- Pointer update: after a packet grant to channel k, p <= (k+1) mod NUM_CH. No packet grant leaves p unchanged.
- packet_gnt = 0 for all channels while cfg wr_en or rd_en is active.
- Config write word select: W = BANK_DATA_WIDTH/CFG_DATA_WIDTH words; index i = addr[log2(BANK_DATA_WIDTH/8)-1 : log2(CFG_DATA_WIDTH/8)]. Data is placed in slice i, bit_sel is all ones in slice i and zero elsewhere. If W=1, the index field is empty and i=0.
- Read tracking: a shift register of depth RD_LAT. Each entry holds {valid, is_cfg, ch_id, word idx}. The entry is pushed in every cycle (valid=mem_rd_en).
- At the pipeline tail, if valid:
  - is_cfg: sram_cfg_rd_data_valid=1 and sram_cfg_rd_data = mem_data_out slice idx.
  - otherwise: packet_rd_data_valid[ch]=1 and packet_rd_data[ch] = mem_data_out.
- Outputs are combinational from the tail and mem_data_out. When not valid, each data output holds its last delivered value (registered copy). Other channels' data is unaffected.
- Back-to-back reads return in issue order, one per cycle, with no bubbles.
- Reset mid-operation: all in-flight reads are dropped, no valid fires afterwards, and held data returns to 0.
- Simultaneous cfg wr and cfg rd: the write wins and the read is ignored; the host guarantees exclusivity.
- Address is passed to memory unmodified (full byte address).

Test Plan:
- Reset, then idle 10 cycles -> all valids 0, all data outputs 0, mem_wr_en=mem_rd_en=0.
- Cfg write addr 0x4 data 0xDEADBEEF, then cfg read 0x4 (DATA 64/CFG 32) -> mem_data_in_bit_sel=0xFFFFFFFF_00000000; rd_data_valid=1 exactly RD_LAT cycles after rd_en with rd_data 0xDEADBEEF.
- Ch0 and ch1 both assert rd_en continuously for 4 cycles, p=0 -> grants ch0,ch1,ch0,ch1; responses at cycles +3..+6 valid on ch0,ch1,ch0,ch1 with matching data.
- Cfg read asserted while ch1 packet write is pending -> ch1 gnt=0 that cycle; write granted the following cycle after cfg_rd drops; the ch1 write is not lost.
- RD_LAT=5 build, ch1 read of addr 0x100 with preloaded 0x0123456789ABCDEF -> packet_rd_data_valid[1] at +5 cycles only; the value is held afterwards; ch0 data unchanged.
- Issue 2 reads, assert reset 1 cycle after issue -> no valid pulses on any channel; data outputs 0.
